mem_arbiter: RTL

Parametrised N-client arbiter for the CPU's single memory port. It generalises the fixed two-client (fetch/data) sharing of the `mem_read`/`mem_write`/`mem_ack` handshake. Sits between the pipeline stages (and any future DMA or debug client) and the memory controller. Grants one request at a time in round-robin order and returns read data and a one-cycle acknowledge to the winning client.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 33 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and transfer op codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2,
        ARB_ERR  = 2'd3
    } arb_state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requester at or after ptr,
// wrapping from N-1 back to 0.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos [N];

    // pos[gi] is the client visited gi steps after ptr; ptr < N so the sum is below 2N
    for (genvar gi = 0; gi < N; gi++) begin : g_pos
        logic [IW:0] sum;
        assign sum     = {1'b0, ptr} + (IW+1)'(gi);
        assign pos[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    end

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[pos[k]]) begin
                valid = 1'b1;
                idx   = pos[k];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin N-client arbiter for the single memory port (IDLE -> BUSY -> DONE).
// Define MEM_ARB_TIMEOUT_EN to add a BUSY watchdog that aborts through the ERR state.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_read,
    input  logic [NUM_PORTS-1:0]          req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ack,
    output logic [NUM_PORTS-1:0]          req_err,
    output logic [DATA_W-1:0]             req_rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_write_data,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_read_data,
    output logic [1:0]                    state,
    output logic [$clog2(NUM_PORTS)-1:0]  grant
);

    localparam int GW = $clog2(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic                 op_q, op_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [NUM_PORTS-1:0] err_q, err_d;

    logic [NUM_PORTS-1:0] grant_onehot;
    logic [GW-1:0]        next_ptr;
    logic                 pick_valid;
    logic [GW-1:0]        pick_idx;
    logic                 pick_op;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    assign timer_inc = timer_q + 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    rr_picker #(
        .N  (NUM_PORTS),
        .IW (GW)
    ) u_picker (
        .req   (req_read | req_write),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A client raising both read and write is served as a write
    assign pick_op = req_write[pick_idx] ? OP_WRITE : OP_READ;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        op_d        = op_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = '0;
        err_d       = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        grant_onehot          = '0;
        grant_onehot[grant_q] = 1'b1;
        next_ptr = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    op_d        = pick_op;
                    mem_addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
                    mem_read_d  = (pick_op == OP_READ);
                    mem_write_d = (pick_op == OP_WRITE);
`ifdef MEM_ARB_TIMEOUT_EN
                    timer_d     = '0;
`endif
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // mem_ack on the expiry cycle still completes normally
                if (mem_ack) begin
                    if (op_q == OP_READ) begin
                        rdata_d = mem_read_data;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ack_d       = grant_onehot;
                    state_d     = ARB_DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timer_inc == TW'(TIMEOUT)) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ack_d       = grant_onehot;
                    err_d       = grant_onehot;
                    rdata_d     = '0;
                    state_d     = ARB_ERR;
                end else begin
                    timer_d     = timer_inc;
                end
`endif
            end
            ARB_DONE: begin
                rr_ptr_d = next_ptr;
                state_d  = ARB_IDLE;
            end
            ARB_ERR: begin
                rr_ptr_d = next_ptr;
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            op_q        <= OP_READ;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= '0;
            err_q       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            op_q        <= op_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
`ifdef MEM_ARB_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign state          = state_q;
    assign grant          = grant_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign req_rdata      = rdata_q;
    assign req_ack        = ack_q;
    assign req_err        = err_q;

endmodule
